// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
//   Round-robin arbiter for the single register-file write port. It is shared
//   by four requesters: WB stage, load-return, multiply unit and debug port.
//   The grant is registered and one-hot. The winner's address and data are
//   muxed onto the write port. One owner may hold the port for at most
//   MAX_HOLD consecutive cycles while another requester is waiting.
// Ports:
//   clk, reset       - clock; synchronous active-high reset
//   req[NREQ]        - level-held write requests
//   req_addr/data    - packed per-requester address / data slices
//   gnt, gnt_id      - registered one-hot grant and its binary index
//   wr_en/addr/data  - register-file write port (combinational from state)
module regfile_wr_arbiter #(
  parameter int NREQ     = 4,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 64,
  parameter int MAX_HOLD = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          gnt,
  output logic [1:0]               gnt_id,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [1:0]      gnt_id_q, gnt_id_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [3:0]      hold_cnt_q, hold_cnt_d;

  logic [NREQ-1:0] others;
  logic            owner_req;

  // First set bit of cand, scanning start, start+1, ... modulo 4.
  function automatic logic [1:0] pick(input logic [NREQ-1:0] cand,
                                      input logic [1:0] start);
    logic [1:0] res;
    logic [1:0] idx;
    logic       found;
    res   = start;
    found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = start + 2'(i);
      if (!found && cand[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    // The owner is excluded here, so a forced release never re-picks it.
    others     = req & ~gnt_q;
    owner_req  = req[gnt_id_q];

    case (state_q)
      IDLE: begin
        if (req != '0) begin
          gnt_id_d        = pick(req, ptr_q);
          gnt_d           = '0;
          gnt_d[gnt_id_d] = 1'b1;
          hold_cnt_d      = '0;
          state_d         = BUSY;
        end
      end
      BUSY: begin
        if (owner_req && (others == '0 || hold_cnt_q < HOLD_LAST)) begin
          if (hold_cnt_q < HOLD_LAST) begin
            hold_cnt_d = hold_cnt_q + 4'd1;
          end
        end else begin
          // Voluntary release and forced release are handled the same way:
          // rotate ptr past the owner and hand over with no idle bubble.
          ptr_d      = gnt_id_q + 2'd1;
          hold_cnt_d = '0;
          if (others != '0) begin
            gnt_id_d        = pick(others, ptr_d);
            gnt_d           = '0;
            gnt_d[gnt_id_d] = 1'b1;
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;

  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    if (state_q == BUSY) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (2'(i) == gnt_id_q) begin
          wr_addr = req_addr[i*ADDR_W +: ADDR_W];
          wr_data = req_data[i*DATA_W +: DATA_W];
        end
      end
    end
    // Writes to the zero register are consumed but never reach the file.
    wr_en = (state_q == BUSY) && owner_req && (wr_addr != '1);
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req = '0;
  logic [19:0]  req_addr = '0;
  logic [255:0] req_data = '0;
  logic [3:0]   gnt;
  logic [1:0]   gnt_id;
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [63:0]  wr_data;

  regfile_wr_arbiter #(.NREQ(4), .ADDR_W(5), .DATA_W(64), .MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
    .req_data(req_data), .gnt(gnt), .gnt_id(gnt_id), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [3:0]  g;
    logic [1:0]  id;
    logic        en;
    logic [4:0]  a;
    logic [63:0] d;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  logic        rst_v = 1'b1;
  logic [3:0]  r_v = '0;
  logic [4:0]  a_v [4];
  logic [63:0] d_v [4];

  // Drive one cycle of stimulus and queue the response expected after the
  // following rising edge.
  task automatic cyc(input string nm, input logic [3:0] eg, input logic [1:0] eid,
                     input logic ew, input logic [4:0] ea, input logic [63:0] ed);
    exp_t e;
    @(negedge clk);
    reset = rst_v;
    req   = r_v;
    for (int i = 0; i < 4; i++) begin
      req_addr[i*5 +: 5]   = a_v[i];
      req_data[i*64 +: 64] = d_v[i];
    end
    e.nm = nm; e.g = eg; e.id = eid; e.en = ew; e.a = ea; e.d = ed;
    sb.push_back(e);
  endtask

  task automatic idle_cyc(input string nm);
    cyc(nm, 4'b0000, 2'd0, 1'b0, 5'd0, 64'd0);
  endtask

  // Monitor: compares every cycle for which an expectation is queued.
  initial begin
    exp_t        e;
    logic [1:0]  act_id;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        act_id = (gnt != 4'b0000) ? gnt_id : 2'd0;
        n_chk++;
        if (gnt !== e.g || act_id !== e.id || wr_en !== e.en ||
            wr_addr !== e.a || wr_data !== e.d) begin
          n_fail++;
          $display("FAIL %s: got gnt=%b id=%0d en=%b addr=%0d data=%h, want gnt=%b id=%0d en=%b addr=%0d data=%h",
                   e.nm, gnt, act_id, wr_en, wr_addr, wr_data,
                   e.g, e.id, e.en, e.a, e.d);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      a_v[i] = 5'(i + 1);
      d_v[i] = 64'h100 + 64'(i);
    end

    // Reset state
    rst_v = 1'b1; r_v = 4'b0000;
    idle_cyc("reset0");
    idle_cyc("reset1");

    // 1: single request, then release to IDLE
    rst_v = 1'b0;
    a_v[0] = 5'd3; d_v[0] = 64'hAA;
    r_v = 4'b0001;
    cyc("t1_grant", 4'b0001, 2'd0, 1'b1, 5'd3, 64'hAA);
    r_v = 4'b0000;
    idle_cyc("t1_idle");

    // Re-reset to return ptr to 0
    rst_v = 1'b1;
    idle_cyc("t2_prereset");
    rst_v = 1'b0;
    a_v[0] = 5'd1; d_v[0] = 64'h100;

    // 2: all requesting, hold limit of 4 with no bubble
    r_v = 4'b1111;
    for (int k = 0; k < 4; k++) cyc("t2_own0", 4'b0001, 2'd0, 1'b1, 5'd1, 64'h100);
    for (int k = 0; k < 4; k++) cyc("t2_own1", 4'b0010, 2'd1, 1'b1, 5'd2, 64'h101);

    // 3: owner 2 drops with req[0] and req[3] pending
    cyc("t3_own2", 4'b0100, 2'd2, 1'b1, 5'd3, 64'h102);
    r_v = 4'b1001;
    cyc("t3_next3", 4'b1000, 2'd3, 1'b1, 5'd4, 64'h103);
    r_v = 4'b0001;
    cyc("t3_then0", 4'b0001, 2'd0, 1'b1, 5'd1, 64'h100);

    // 4: lone owner held past saturation, then a competitor arrives
    for (int k = 0; k < 20; k++) cyc("t4_hold", 4'b0001, 2'd0, 1'b1, 5'd1, 64'h100);
    r_v = 4'b0011;
    cyc("t4_preempt", 4'b0010, 2'd1, 1'b1, 5'd2, 64'h101);

    // 5: write to register 31 is suppressed, a following one is not
    r_v = 4'b0010;
    a_v[1] = 5'd31;
    cyc("t5_xzr", 4'b0010, 2'd1, 1'b0, 5'd31, 64'h101);
    a_v[1] = 5'd5; d_v[1] = 64'h55;
    cyc("t5_addr5", 4'b0010, 2'd1, 1'b1, 5'd5, 64'h55);

    // 6: reset in the middle of a grant to requester 2
    r_v = 4'b0100;
    cyc("t6_own2", 4'b0100, 2'd2, 1'b1, 5'd3, 64'h102);
    rst_v = 1'b1;
    idle_cyc("t6_reset");
    rst_v = 1'b0; r_v = 4'b0110;
    cyc("t6_ptr0", 4'b0010, 2'd1, 1'b1, 5'd5, 64'h55);

    r_v = 4'b0000;
    repeat (3) @(posedge clk);
    #2;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
